// File: rtl/ramp_phase_source_pkg.sv
// Shared constants for the ramp phase source and its consumers.
//   PHASE_W                       accumulator / stream width
//   CNT_W                         default period counter width
//   RAMP_PHASE_MSB/LSB            13-bit ramp phase slice of the phase word
//   RAMP_FULL_SCALE               number of distinct ramp phase slice values
//   ramp_slice()                  extracts the ramp phase slice from a phase word
package ramp_phase_source_pkg;

    localparam int PHASE_W         = 48;
    localparam int CNT_W           = 32;
    localparam int RAMP_PHASE_MSB  = 47;
    localparam int RAMP_PHASE_LSB  = 35;
    localparam int RAMP_PHASE_W    = RAMP_PHASE_MSB - RAMP_PHASE_LSB + 1;
    localparam int RAMP_FULL_SCALE = 8192;

    function automatic logic [RAMP_PHASE_W-1:0] ramp_slice(input logic [PHASE_W-1:0] phase);
        return phase[RAMP_PHASE_MSB:RAMP_PHASE_LSB];
    endfunction

endpackage

// File: rtl/ramp_phase_source_phase_acc_core.sv
// Phase accumulator with deferred increment update.
//   clk, aresetn     clock, synchronous active-low reset
//   advance          step acc by the active increment (one emitted beat)
//   restart_load     restart: acc becomes the (possibly new) increment, because
//                    the beat emitted in the same cycle carries phase 0
//   restart_idle     restart while nothing is emitted: acc becomes 0
//   pinc/pinc_valid  increment request into the shadow register
//   acc              phase of the next beat to emit
//   carry            carry-out of acc + active increment
//   update_pending   shadow increment not yet applied
module ramp_phase_source_phase_acc_core
    import ramp_phase_source_pkg::*;
#(
    parameter int PHASE_W        = ramp_phase_source_pkg::PHASE_W,
    parameter int UPDATE_AT_WRAP = 1
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               advance,
    input  logic               restart_load,
    input  logic               restart_idle,
    input  logic [PHASE_W-1:0] pinc,
    input  logic               pinc_valid,
    output logic [PHASE_W-1:0] acc,
    output logic               carry,
    output logic               update_pending
);

    logic [PHASE_W:0]   sum;
    logic [PHASE_W-1:0] active_pinc;
    logic [PHASE_W-1:0] shadow_pinc;
    logic [PHASE_W-1:0] shadow_eff;
    logic [PHASE_W-1:0] step_eff;
    logic               pend_eff;
    logic               apply;

    // A request arriving this cycle is seen as already latched, so a
    // same-cycle restart or wrap picks up the newest increment.
    always_comb begin
        sum        = {1'b0, acc} + {1'b0, active_pinc};
        shadow_eff = pinc_valid ? pinc : shadow_pinc;
        pend_eff   = pinc_valid | update_pending;
        // A stopped accumulator never wraps, so its update cannot wait.
        apply      = pend_eff & ((active_pinc == '0) | restart_load | restart_idle |
                     (advance & ((UPDATE_AT_WRAP == 0) | sum[PHASE_W])));
        step_eff   = apply ? shadow_eff : active_pinc;
    end

    assign carry = sum[PHASE_W];

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            acc            <= '0;
            active_pinc    <= '0;
            shadow_pinc    <= '0;
            update_pending <= 1'b0;
        end else begin
            shadow_pinc    <= shadow_eff;
            active_pinc    <= step_eff;
            update_pending <= pend_eff & ~apply;
            if (restart_load)
                acc <= step_eff;
            else if (restart_idle)
                acc <= '0;
            else if (advance)
                acc <= sum[PHASE_W-1:0];
        end
    end

endmodule

// File: rtl/ramp_phase_source.sv
// AXI-Stream phase word source for the ramper / DDS lookup.
//   clk, aresetn          clock, synchronous active-low reset
//   enable                run the accumulator and stream
//   sync_reset            pulse: restart phase at 0, clear period count
//   pinc, pinc_valid      increment request (shadowed, applied at wrap or next beat)
//   poff                  static offset added to the emitted phase
//   m_axis_*_phase        stream output (tdata = acc + poff)
//   wrap                  first beat of a new period
//   period_count          completed wraps since reset/sync, saturating
//   update_pending        shadow increment not yet applied
module ramp_phase_source
    import ramp_phase_source_pkg::*;
#(
    parameter int PHASE_W        = ramp_phase_source_pkg::PHASE_W,
    parameter int CNT_W          = ramp_phase_source_pkg::CNT_W,
    parameter int UPDATE_AT_WRAP = 1
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               enable,
    input  logic               sync_reset,
    input  logic [PHASE_W-1:0] pinc,
    input  logic               pinc_valid,
    input  logic [PHASE_W-1:0] poff,
    output logic [PHASE_W-1:0] m_axis_tdata_phase,
    output logic               m_axis_tvalid_phase,
    input  logic               m_axis_tready_phase,
    output logic               wrap,
    output logic [CNT_W-1:0]   period_count,
    output logic               update_pending
);

    logic               load;
    logic               sync_pend;
    logic               sync_eff;
    logic               restart_load;
    logic               restart_idle;
    logic               advance;
    logic               carry;
    logic               wrap_next;
    logic [PHASE_W-1:0] acc;

    // The output register takes a new beat whenever it is empty or its beat
    // is leaving; acc always holds the phase of that next beat.
    always_comb begin
        load         = enable & (~m_axis_tvalid_phase | m_axis_tready_phase);
        sync_eff     = sync_reset | sync_pend;
        restart_load = load & sync_eff;
        restart_idle = ~load & sync_reset & ~m_axis_tvalid_phase;
        advance      = load & ~sync_eff;
    end

    ramp_phase_source_phase_acc_core #(
        .PHASE_W        (PHASE_W),
        .UPDATE_AT_WRAP (UPDATE_AT_WRAP)
    ) u_phase_acc_core (
        .clk            (clk),
        .aresetn        (aresetn),
        .advance        (advance),
        .restart_load   (restart_load),
        .restart_idle   (restart_idle),
        .pinc           (pinc),
        .pinc_valid     (pinc_valid),
        .acc            (acc),
        .carry          (carry),
        .update_pending (update_pending)
    );

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            m_axis_tdata_phase  <= '0;
            m_axis_tvalid_phase <= 1'b0;
            wrap                <= 1'b0;
            period_count        <= '0;
            sync_pend           <= 1'b0;
            wrap_next           <= 1'b0;
        end else begin
            if (load) begin
                m_axis_tdata_phase  <= (restart_load ? '0 : acc) + poff;
                m_axis_tvalid_phase <= 1'b1;
                wrap                <= restart_load | wrap_next;
                if (restart_load)
                    period_count <= '0;
                else if (wrap_next && !(&period_count))
                    period_count <= period_count + 1'b1;
            end else begin
                if (m_axis_tvalid_phase && m_axis_tready_phase) begin
                    m_axis_tvalid_phase <= 1'b0;
                    wrap                <= 1'b0;
                end
                if (restart_idle)
                    period_count <= '0;
            end

            // A restart that cannot be emitted yet is remembered so the next
            // beat still starts the new period.
            if (load)
                sync_pend <= 1'b0;
            else if (sync_reset)
                sync_pend <= 1'b1;

            // Carry of the step just taken marks the beat after it as a wrap.
            if (restart_load || restart_idle)
                wrap_next <= 1'b0;
            else if (advance)
                wrap_next <= carry;
        end
    end

endmodule

// File: tb/tb_ramp_phase_source.sv
module tb_ramp_phase_source;
    import ramp_phase_source_pkg::*;

    localparam logic [63:0] MASK = (64'd1 << 48) - 64'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn = 1'b0, enable = 1'b0, sync_reset = 1'b0, pinc_valid = 1'b0, tready = 1'b1;
    logic [47:0] pinc = '0, poff = '0;

    // dut0: apply-on-next-beat, 3-bit counter (reaches saturation); dut1: apply-at-wrap, 32-bit
    logic [47:0] tdata0, tdata1;
    logic        tvalid0, tvalid1, wrap0, wrap1, pend0, pend1;
    logic [2:0]  cnt0;
    logic [31:0] cnt1;

    ramp_phase_source #(.PHASE_W(48), .CNT_W(3), .UPDATE_AT_WRAP(0)) dut0 (
        .clk(clk), .aresetn(aresetn), .enable(enable), .sync_reset(sync_reset),
        .pinc(pinc), .pinc_valid(pinc_valid), .poff(poff),
        .m_axis_tdata_phase(tdata0), .m_axis_tvalid_phase(tvalid0), .m_axis_tready_phase(tready),
        .wrap(wrap0), .period_count(cnt0), .update_pending(pend0));

    ramp_phase_source #(.PHASE_W(48), .CNT_W(32), .UPDATE_AT_WRAP(1)) dut1 (
        .clk(clk), .aresetn(aresetn), .enable(enable), .sync_reset(sync_reset),
        .pinc(pinc), .pinc_valid(pinc_valid), .poff(poff),
        .m_axis_tdata_phase(tdata1), .m_axis_tvalid_phase(tvalid1), .m_axis_tready_phase(tready),
        .wrap(wrap1), .period_count(cnt1), .update_pending(pend1));

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Beat-stream model: next_phase is the phase of the next beat to be emitted,
    // step the increment in use, sh/pend the requested increment awaiting use.
    logic [63:0] m_next[2], m_step[2], m_sh[2], m_tdata[2], m_cnt[2];
    bit          m_pend[2], m_carry[2], m_sync[2], m_tvalid[2], m_wrap[2];

    function automatic logic [63:0] cmax(input int u);
        return (u == 0) ? 64'd7 : 64'hFFFF_FFFF;
    endfunction

    task automatic model_step(input int u);
        logic [63:0] sh_e, s;
        bit pend_e, emit, sync_e, apply, was_valid;
        if (!aresetn) begin
            m_next[u] = 0; m_step[u] = 0; m_sh[u] = 0; m_tdata[u] = 0; m_cnt[u] = 0;
            m_pend[u] = 0; m_carry[u] = 0; m_sync[u] = 0; m_tvalid[u] = 0; m_wrap[u] = 0;
            return;
        end
        sh_e      = pinc_valid ? 64'(pinc) : m_sh[u];
        pend_e    = pinc_valid || m_pend[u];
        was_valid = m_tvalid[u];
        emit      = enable && (!was_valid || tready);
        sync_e    = sync_reset || m_sync[u];
        apply     = pend_e && (m_step[u] == 0);
        if (emit && sync_e) begin
            apply       = pend_e;
            m_tdata[u]  = 64'(poff);
            m_wrap[u]   = 1; m_tvalid[u] = 1; m_cnt[u] = 0; m_carry[u] = 0; m_sync[u] = 0;
            m_next[u]   = apply ? sh_e : m_step[u];
        end else if (emit) begin
            m_tdata[u]  = (m_next[u] + 64'(poff)) & MASK;
            m_wrap[u]   = m_carry[u];
            m_tvalid[u] = 1;
            if (m_carry[u] && m_cnt[u] < cmax(u)) m_cnt[u] = m_cnt[u] + 1;
            s           = m_next[u] + m_step[u];
            m_carry[u]  = s[48];
            m_next[u]   = s & MASK;
            if (pend_e && (u == 0 || s[48])) apply = 1;
        end else begin
            if (was_valid && tready) begin m_tvalid[u] = 0; m_wrap[u] = 0; end
            if (sync_reset) begin
                m_sync[u] = 1;
                if (!was_valid) begin
                    m_next[u] = 0; m_cnt[u] = 0; m_carry[u] = 0; apply = pend_e;
                end
            end
        end
        if (apply) begin m_step[u] = sh_e; m_pend[u] = 0; end
        else m_pend[u] = pend_e;
        m_sh[u] = sh_e;
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Compare process: every cycle, plus stability of a stalled beat.
    bit          chk_on = 0;
    bit          pv0 = 0, pv1 = 0, pw0 = 0, pw1 = 0;
    logic [47:0] pd0 = '0, pd1 = '0;

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("d0_tdata",  64'(tdata0),  m_tdata[0]);
            chk("d0_tvalid", 64'(tvalid0), 64'(m_tvalid[0]));
            chk("d0_wrap",   64'(wrap0),   64'(m_wrap[0]));
            chk("d0_count",  64'(cnt0),    m_cnt[0]);
            chk("d0_pend",   64'(pend0),   64'(m_pend[0]));
            chk("d1_tdata",  64'(tdata1),  m_tdata[1]);
            chk("d1_tvalid", 64'(tvalid1), 64'(m_tvalid[1]));
            chk("d1_wrap",   64'(wrap1),   64'(m_wrap[1]));
            chk("d1_count",  64'(cnt1),    m_cnt[1]);
            chk("d1_pend",   64'(pend1),   64'(m_pend[1]));
            if (aresetn && !tready) begin
                if (pv0) begin
                    chk("d0_stall_tdata", 64'(tdata0), 64'(pd0));
                    chk("d0_stall_wrap",  64'(wrap0),  64'(pw0));
                end
                if (pv1) begin
                    chk("d1_stall_tdata",  64'(tdata1),  64'(pd1));
                    chk("d1_stall_wrap",   64'(wrap1),   64'(pw1));
                    chk("d1_stall_tvalid", 64'(tvalid1), 64'd1);
                end
            end
        end
        pv0 = tvalid0; pd0 = tdata0; pw0 = wrap0;
        pv1 = tvalid1; pd1 = tdata1; pw1 = wrap1;
    end

    function automatic logic [47:0] rnd48();
        return {16'($urandom_range(0, 65535)), 32'($urandom)};
    endfunction

    logic [12:0] cur, prv, dif;

    task automatic wait_slice1(input int target, input int bound, input string nm);
        int n = 0;
        while (!(tvalid1 && ramp_slice(tdata1) == 13'(target)) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(n < bound), 64'd1);
    endtask

    initial begin
        logic [47:0] p2, po;
        logic [63:0] prod, prodp;
        int k, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk_on = 1;
        chk("rst_tvalid", 64'(tvalid1), 64'd0);
        chk("rst_tdata",  64'(tdata1),  64'd0);
        chk("rst_count",  64'(cnt1),    64'd0);
        chk("rst_pend",   64'(pend1),   64'd0);

        // Full ramp period with step 2^35
        aresetn = 1; pinc = 48'd1 << 35; pinc_valid = 1;
        @(negedge clk);
        chk("t1_pend_immediate", 64'(pend1), 64'd0);
        pinc_valid = 0; enable = 1;
        for (int i = 0; i <= RAMP_FULL_SCALE; i++) begin
            @(negedge clk);
            if (i == 0) chk("t1_tvalid", 64'(tvalid1), 64'd1);
            chk("t1_slice", 64'(ramp_slice(tdata1)), 64'(i % RAMP_FULL_SCALE));
            chk("t1_model_slice", 64'(m_tdata[1][47:35]), 64'(i % RAMP_FULL_SCALE));
            chk("t1_wrap", 64'(wrap1), 64'(i == RAMP_FULL_SCALE));
        end
        chk("t1_count1", 64'(cnt1), 64'd1);
        chk("t1_count0", 64'(cnt0), 64'd1);

        // Update deferred to wrap
        wait_slice1(100, 200, "t3_reach_100");
        pinc = 48'd1 << 36; pinc_valid = 1;
        @(negedge clk);
        pinc_valid = 0;
        chk("t3_pend_set", 64'(pend1), 64'd1);
        prv = ramp_slice(tdata1);
        n = 0;
        while (!wrap1 && n < 9000) begin
            @(negedge clk);
            n++;
            cur = ramp_slice(tdata1);
            dif = cur - prv;
            chk("t3_old_step", 64'(dif), 64'd1);
            if (cur == 13'd8190) chk("t3_pend_before", 64'(pend1), 64'd1);
            prv = cur;
        end
        chk("t3_wrap_seen", 64'(n < 9000), 64'd1);
        chk("t3_wrap_slice", 64'(ramp_slice(tdata1)), 64'd0);
        chk("t3_pend_clear", 64'(pend1), 64'd0);
        @(negedge clk);
        chk("t3_new_step", 64'(ramp_slice(tdata1)), 64'd2);

        // sync_reset together with a new increment
        wait_slice1(4000, 5000, "t4_reach_4000");
        po = rnd48();
        sync_reset = 1; pinc_valid = 1; pinc = 48'd3 << 35; poff = po;
        @(negedge clk);
        sync_reset = 0; pinc_valid = 0;
        chk("t4_tdata",  64'(tdata1), 64'(po));
        chk("t4_wrap",   64'(wrap1),  64'd1);
        chk("t4_count",  64'(cnt1),   64'd0);
        chk("t4_tdata0", 64'(tdata0), 64'(po));
        @(negedge clk);
        chk("t4_step", 64'(tdata1), ((64'd3 << 35) + 64'(po)) & MASK);

        // enable gap
        sync_reset = 1; pinc_valid = 1; pinc = 48'd1 << 35; poff = '0;
        @(negedge clk);
        sync_reset = 0; pinc_valid = 0;
        wait_slice1(100, 200, "t5_reach_100");
        enable = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0 || i == 49) chk("t5_gap", 64'(tvalid1), 64'd0);
        end
        enable = 1;
        @(negedge clk);
        chk("t5_resume_valid", 64'(tvalid1), 64'd1);
        chk("t5_resume_slice", 64'(ramp_slice(tdata1)), 64'd101);

        // Reset while stalled
        tready = 0;
        repeat (10) @(negedge clk);
        chk("t6_stalled_valid", 64'(tvalid1), 64'd1);
        aresetn = 0; enable = 0;
        @(negedge clk);
        chk("t6_tvalid", 64'(tvalid1), 64'd0);
        chk("t6_tdata",  64'(tdata1),  64'd0);
        chk("t6_wrap",   64'(wrap1),   64'd0);
        chk("t6_count",  64'(cnt1),    64'd0);
        chk("t6_pend",   64'(pend1),   64'd0);
        aresetn = 1; tready = 1;

        // Random stalls: accepted beat k must be k*pinc + poff regardless of stalls
        p2 = {16'($urandom_range(256, 16383)), 32'($urandom)};
        po = rnd48();
        pinc = p2; poff = po; pinc_valid = 1;
        @(negedge clk);
        pinc_valid = 0; enable = 1;
        k = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            tready = ($urandom % 3) != 0;
            if (tvalid1 && tready) begin
                prod  = 64'(k) * 64'(p2);
                prodp = (k == 0) ? 64'd0 : 64'(k - 1) * 64'(p2);
                chk("t2_tdata1", 64'(tdata1), (prod + 64'(po)) & MASK);
                chk("t2_tdata0", 64'(tdata0), (prod + 64'(po)) & MASK);
                chk("t2_wrap",   64'(wrap1),  64'(k > 0 && (prod >> 48) != (prodp >> 48)));
                chk("t2_count1", 64'(cnt1),   prod >> 48);
                chk("t2_count0", 64'(cnt0),   ((prod >> 48) > 7) ? 64'd7 : (prod >> 48));
                k++;
            end
        end
        chk("t2_progress", 64'(k > 500), 64'd1);

        // Free random run against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            tready     = ($urandom % 4) != 0;
            enable     = ($urandom % 16) != 0;
            sync_reset = ($urandom % 64) == 0;
            pinc_valid = ($urandom % 24) == 0;
            pinc       = (($urandom % 8) == 0) ? 48'd0 : {16'($urandom_range(64, 65535)), 32'($urandom)};
            if (($urandom % 50) == 0) poff = rnd48();
            aresetn    = ($urandom % 600) != 0;
        end
        aresetn = 1; sync_reset = 0; pinc_valid = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
